// File: rtl/pcm_i2s_tx.sv
// I2S transmitter: FIFO-buffered 24-bit PCM serialized as bclk/lrclk/sdata from clk_i.
// Define LJ_FORMAT_EN for left-justified framing (no one-bit delay) instead of I2S.
module pcm_i2s_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          ena_i,
  input  logic                          chan_i,
  output logic                          bclk_o,
  output logic                          lrclk_o,
  output logic                          sdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          underrun_o,
  output logic                          overrun_o,
  output logic                          misalign_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int CNT_W = $clog2(SLOT_W);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                en_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                chan_q, chan_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic                misalign_q, misalign_d;

  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_addr;
  logic [LVL_W-1:0]    count_q, count_d;

  logic                fall;
  logic                slot_start;
  logic                empty;
  logic                full;
  logic                flush;
  logic                pop;
  logic                wr;
  logic [DATA_W:0]     head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Serial bit carried at a given slot position; positions outside the word are zero.
  function automatic logic fmt_bit(input logic [DATA_W-1:0] word, input logic [CNT_W-1:0] cnt);
    logic             res;
    logic [IDX_W-1:0] idx;
    res = 1'b0;
    idx = '0;
`ifdef LJ_FORMAT_EN
    if (int'(cnt) < DATA_W) begin
      idx = IDX_W'(DATA_W - 1 - int'(cnt));
      res = word[idx];
    end
`else
    if (int'(cnt) >= 1 && int'(cnt) <= DATA_W) begin
      idx = IDX_W'(DATA_W - int'(cnt));
      res = word[idx];
    end
`endif
    return res;
  endfunction

  assign fall       = enable_i && (div_q == DIV_W'(BCLK_DIV - 1));
  assign slot_start = fall && (bit_q == CNT_W'(SLOT_W - 1));
  assign empty      = (count_q == '0);
  assign full       = (count_q == LVL_W'(FIFO_DEPTH));
  assign flush      = en_q && !enable_i;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    chan_d     = chan_q;
    word_d     = word_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    misalign_d = 1'b0;
    pop        = 1'b0;
    if (!enable_i) begin
      div_d   = '0;
      bit_d   = CNT_W'(SLOT_W - 1);
      chan_d  = 1'b1;
      word_d  = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
    end else begin
      div_d  = fall ? '0 : div_q + DIV_W'(1);
      bclk_d = (div_d >= DIV_W'(BCLK_DIV / 2));
      if (fall) begin
        bit_d = (bit_q == CNT_W'(SLOT_W - 1)) ? '0 : bit_q + CNT_W'(1);
        if (slot_start) begin
          chan_d  = ~chan_q;
          lrclk_d = chan_d;
          // A wrong-channel head is left in place so it lines up with the following slot.
          if (empty) begin
            word_d     = '0;
            underrun_d = 1'b1;
          end else if (head[DATA_W] == chan_d) begin
            word_d = head[DATA_W-1:0];
            pop    = 1'b1;
          end else begin
            word_d     = '0;
            misalign_d = 1'b1;
          end
        end
        sdata_d = fmt_bit(word_d, bit_d);
      end
    end
  end

  always_comb begin
    wr        = ena_i && (!full || pop || flush);
    overrun_d = ena_i && full && !pop && !flush;
    wr_addr   = flush ? '0 : wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = wr ? ptr_inc('0) : '0;
      count_d  = wr ? LVL_W'(1) : '0;
    end else begin
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr)  wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({wr, pop})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      div_q      <= '0;
      bit_q      <= CNT_W'(SLOT_W - 1);
      chan_q     <= 1'b1;
      word_q     <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      misalign_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      en_q       <= enable_i;
      div_q      <= div_d;
      bit_q      <= bit_d;
      chan_q     <= chan_d;
      word_q     <= word_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      misalign_q <= misalign_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_addr] <= {chan_i, data_i};
  end

  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign level_o    = count_q;
  assign underrun_o = underrun_q;
  assign overrun_o  = overrun_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: slot-arithmetic reference model with per-cycle compare, plus directed literal checks.
module tb_pcm_i2s_tx;
  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int BCLK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              ena = 1'b0;
  logic              chan = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              bclk, lrclk, sdata, underrun, overrun, misalign;
  logic [LVL_W-1:0]  level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pcm_i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .data_i(data), .ena_i(ena), .chan_i(chan),
    .bclk_o(bclk), .lrclk_o(lrclk), .sdata_o(sdata), .level_o(level),
    .underrun_o(underrun), .overrun_o(overrun), .misalign_o(misalign)
  );

  function automatic bit in_word(input int p);
`ifdef LJ_FORMAT_EN
    return (p >= 0 && p < DATA_W);
`else
    return (p >= 1 && p <= DATA_W);
`endif
  endfunction

  function automatic logic fmt(input logic [DATA_W-1:0] w, input int b);
`ifdef LJ_FORMAT_EN
    if (b < DATA_W) return w[DATA_W-1-b];
`else
    if (b >= 1 && b <= DATA_W) return w[DATA_W-b];
`endif
    return 1'b0;
  endfunction

  // Reference model: position within the frame is derived from the count of enabled cycles.
  logic [DATA_W:0]   q[$];
  int                m_n, f, b, s;
  bit                m_en_prev;
  logic [DATA_W-1:0] m_word;
  logic              e_bclk, e_lr, e_sd, e_ur, e_or, e_mis;
  int                e_lvl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_n = 0; m_en_prev = 0; m_word = '0;
      e_bclk = 0; e_lr = 0; e_sd = 0; e_ur = 0; e_or = 0; e_mis = 0; e_lvl = 0;
    end else begin
      e_ur = 0; e_or = 0; e_mis = 0;
      if (!enable) begin
        if (m_en_prev) q.delete();
        m_n = 0; m_word = '0;
        e_bclk = 0; e_lr = 0; e_sd = 0;
      end else begin
        m_n++;
        f = m_n / BCLK_DIV;
        e_bclk = ((m_n % BCLK_DIV) >= BCLK_DIV / 2);
        if (f == 0) begin
          e_lr = 0; e_sd = 0;
        end else begin
          b = (f - 1) % SLOT_W;
          s = (f - 1) / SLOT_W;
          if ((m_n % BCLK_DIV) == 0 && b == 0) begin
            if (q.size() == 0) begin
              m_word = '0; e_ur = 1;
            end else if (q[0][DATA_W] == (s % 2)) begin
              m_word = q[0][DATA_W-1:0];
              void'(q.pop_front());
            end else begin
              m_word = '0; e_mis = 1;
            end
          end
          e_lr = ((s % 2) == 1);
          e_sd = fmt(m_word, b);
        end
      end
      if (ena) begin
        if (q.size() < FIFO_DEPTH) q.push_back({chan, data});
        else e_or = 1;
      end
      m_en_prev = enable;
      e_lvl = q.size();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ({bclk, lrclk, sdata, underrun, overrun, misalign} !== {e_bclk, e_lr, e_sd, e_ur, e_or, e_mis}
          || level !== LVL_W'(e_lvl)) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got bclk/lr/sd/ur/or/mis=%b%b%b%b%b%b lvl=%0d, expected %b%b%b%b%b%b lvl=%0d",
                 $time, bclk, lrclk, sdata, underrun, overrun, misalign, level,
                 e_bclk, e_lr, e_sd, e_ur, e_or, e_mis, e_lvl);
      end
    end
  end

  // Independent receiver and pulse counters for the literal checks.
  int                cyc = 0, n_ur = 0, n_or = 0, n_mis = 0, n_extra = 0;
  int                pos = -2;
  int                lr_rise = 0, lr_rise_prev = 0, bk_rise = 0, bk_rise_prev = 0;
  logic              prev_bclk = 0, prev_lr = 0, slot_lr = 0;
  logic [DATA_W-1:0] sh = '0;
  logic [DATA_W:0]   rx[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pos = -2; slot_lr = 0; sh = '0; prev_bclk = 0; prev_lr = 0;
    end else begin
      if (underrun) n_ur++;
      if (overrun)  n_or++;
      if (misalign) n_mis++;
      if (lrclk && !prev_lr) begin lr_rise_prev = lr_rise; lr_rise = cyc; end
      if (bclk && !prev_bclk) begin
        bk_rise_prev = bk_rise; bk_rise = cyc;
        if (enable) begin
          if (lrclk != slot_lr) pos = 0; else pos++;
          slot_lr = lrclk;
          if (in_word(pos)) sh = {sh[DATA_W-2:0], sdata};
          else if (pos >= 0 && sdata) n_extra++;
          if (pos == SLOT_W - 1) begin rx.push_back({lrclk, sh}); sh = '0; end
        end
      end
      if (!enable) begin pos = -2; slot_lr = 0; sh = '0; end
      prev_bclk = bclk; prev_lr = lrclk;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic c, input logic [DATA_W-1:0] d);
    ena = 1; chan = c; data = d; tick(); ena = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD_BEEF;
  endfunction

  int   base, base2, first;
  logic c_next;
  logic s_at [1:12];

  initial begin
    tick(3);
    check("reset_outputs", 32'({bclk, lrclk, sdata, underrun, overrun, misalign, level}), 32'h0);
    rst = 0;
    tick(2);

    // Two samples then enable: exact words, frame and bit clock periods.
    wr(0, 24'hA5A5A5);
    wr(1, 24'h5A5A5A);
    tick();
    check("level_two", 32'(level), 32'd2);
    base = rx.size(); base2 = n_ur;
    enable = 1;
    tick(514);
    check("b_left_word",  rx_at(base),     {7'd0, 1'b0, 24'hA5A5A5});
    check("b_right_word", rx_at(base + 1), {7'd0, 1'b1, 24'h5A5A5A});
    check("lrclk_period", 32'(lr_rise - lr_rise_prev), 32'd256);
    check("bclk_period",  32'(bk_rise - bk_rise_prev), 32'd4);
    check("b_underruns",  32'(n_ur - base2), 32'd2);
    enable = 0;
    tick(3);

    // Empty FIFO: first slot at cycle 4, one underrun per slot.
    base2 = n_ur; first = 0;
    enable = 1;
    for (int k = 1; k <= 514; k++) begin
      tick();
      if (underrun && first == 0) first = k;
    end
    check("first_slot_cycle", 32'(first), 32'd4);
    check("empty_underruns",  32'(n_ur - base2), 32'd4);
    check("empty_level",      32'(level), 32'd0);
    enable = 0;
    tick(3);

    // Five writes into a four-deep FIFO while disabled.
    base2 = n_or;
    ena = 1;
    for (int i = 1; i <= 5; i++) begin
      chan = ((i % 2) == 0);
      data = 24'(i * 24'h111111);
      tick();
    end
    ena = 0;
    tick();
    check("overrun_count", 32'(n_or - base2), 32'd1);
    check("level_full",    32'(level), 32'd4);
    base = rx.size();
    enable = 1;
    tick(660);
    check("d_word0", rx_at(base),     {7'd0, 1'b0, 24'h111111});
    check("d_word1", rx_at(base + 1), {7'd0, 1'b1, 24'h222222});
    check("d_word2", rx_at(base + 2), {7'd0, 1'b0, 24'h333333});
    check("d_word3", rx_at(base + 3), {7'd0, 1'b1, 24'h444444});
    check("d_word4", rx_at(base + 4), {7'd0, 1'b0, 24'h000000});
    enable = 0;
    tick(3);

    // Stray right sample first: misaligned left slot then resync.
    base2 = n_mis;
    wr(1, 24'h123456);
    wr(0, 24'h000001);
    wr(1, 24'h00000F);
    base = rx.size();
    enable = 1;
    tick(530);
    check("misalign_count", 32'(n_mis - base2), 32'd1);
    check("e_word0", rx_at(base),     {7'd0, 1'b0, 24'h000000});
    check("e_word1", rx_at(base + 1), {7'd0, 1'b1, 24'h123456});
    check("e_word2", rx_at(base + 2), {7'd0, 1'b0, 24'h000001});
    check("e_word3", rx_at(base + 3), {7'd0, 1'b1, 24'h00000F});
    enable = 0;
    tick(3);

    // Single MSB-only sample: position of the one bit in the first left slot.
    wr(0, 24'h800000);
    enable = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      s_at[k] = sdata;
    end
    check("msb_lr_at_slot", 32'(lrclk), 32'd0);
`ifdef LJ_FORMAT_EN
    check("lj_bit0", 32'(s_at[4]),  32'd1);
    check("lj_bit1", 32'(s_at[8]),  32'd0);
    check("lj_bit2", 32'(s_at[12]), 32'd0);
`else
    check("i2s_bit0", 32'(s_at[4]),  32'd0);
    check("i2s_bit1", 32'(s_at[8]),  32'd1);
    check("i2s_bit2", 32'(s_at[12]), 32'd0);
`endif

    // Randomized traffic with enable toggles and one mid-frame reset.
    c_next = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        ena = 0; enable = 1;
        rst = 1;
        #1;
        check("midframe_reset", 32'({bclk, lrclk, sdata, underrun, overrun, misalign, level}), 32'h0);
        tick(2);
        rst = 0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
          tick();
          if (underrun && first == 0) first = k;
        end
        check("post_reset_slot", 32'(first), 32'd4);
      end
      tick();
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      ena = ($urandom_range(0, 79) == 0);
      if (ena) begin
        chan = c_next;
        data = DATA_W'($urandom);
        if ($urandom_range(0, 7) != 0) c_next = ~c_next;
      end
    end
    ena = 0;
    tick(4);
    check("no_stray_bits", 32'(n_extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
